// File: rtl/interrupt_responder.sv
// Interrupt responder: edge-captured sticky pending flags, fixed-priority selection,
// and a request/acknowledge/service handshake with the CPU (no nesting).
module interrupt_responder #(
    parameter int unsigned N     = 4,
    parameter int unsigned VEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     irq_src,
    input  logic [N-1:0]     irq_en,
    input  logic             gie,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             irq,
    output logic [VEC_W-1:0] irq_id,
    output logic             busy,
    output logic [N-1:0]     pending
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    state_e           state;
    logic [N-1:0]     src_d;
    logic [N-1:0]     rise;
    logic [N-1:0]     eligible;
    logic [N-1:0]     clr;
    logic [VEC_W-1:0] sel;
    logic             ack_hit;
    logic             withdraw;

    always_comb begin
        rise     = irq_src & ~src_d;
        eligible = pending & irq_en & {N{gie}};
        // Scan downwards so the lowest eligible index is the last one written.
        sel = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible[i]) sel = VEC_W'(i);
        end
        ack_hit  = (state == StReq) && int_ack;
        withdraw = !gie || !irq_en[irq_id];
        clr      = '0;
        if (ack_hit) clr[irq_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            src_d   <= '0;
            pending <= '0;
            irq_id  <= '0;
            irq     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            src_d   <= irq_src;
            // A new edge on the bit being acknowledged survives the clear.
            pending <= (pending & ~clr) | rise;
            unique case (state)
                StIdle: begin
                    if (|eligible) begin
                        irq_id <= sel;
                        state  <= StReq;
                        irq    <= 1'b1;
                    end
                end
                StReq: begin
                    if (int_ack) begin
                        state <= StService;
                        irq   <= 1'b0;
                        busy  <= 1'b1;
                    end else if (withdraw) begin
                        state <= StIdle;
                        irq   <= 1'b0;
                    end
                end
                StService: begin
                    if (int_done) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    irq   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_responder.sv
// Bench for interrupt_responder: directed handshake scenarios plus random traffic, with a
// per-cycle expected-output queue drained by an independent monitor.
module tb_interrupt_responder;

    localparam int N     = 4;
    localparam int VEC_W = 2;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;

    typedef struct packed {
        logic             irq;
        logic             busy;
        logic [VEC_W-1:0] id;
        logic [N-1:0]     pend;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     irq_src = '0;
    logic [N-1:0]     irq_en = '0;
    logic             gie = 1'b0;
    logic             int_ack = 1'b0;
    logic             int_done = 1'b0;
    logic             irq;
    logic [VEC_W-1:0] irq_id;
    logic             busy;
    logic [N-1:0]     pending;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model state
    int           m_mode = M_IDLE;
    int           m_id   = 0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_prev = '0;

    interrupt_responder #(
        .N     (N),
        .VEC_W (VEC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .irq_en   (irq_en),
        .gie      (gie),
        .int_ack  (int_ack),
        .int_done (int_done),
        .irq      (irq),
        .irq_id   (irq_id),
        .busy     (busy),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock of the handshake described in terms of modes and a pending set.
    function automatic void model_step();
        logic [N-1:0] rises;
        int           pick;
        rises = irq_src & ~m_prev;
        if (m_mode == M_IDLE) begin
            pick = gie ? lowest(m_pend & irq_en) : -1;
            if (pick >= 0) begin
                m_mode = M_REQ;
                m_id   = pick;
            end
        end else if (m_mode == M_REQ) begin
            if (int_ack) begin
                m_pend[m_id] = 1'b0;
                m_mode       = M_SVC;
            end else if (!gie || !irq_en[m_id]) begin
                m_mode = M_IDLE;
            end
        end else if (int_done) begin
            m_mode = M_IDLE;
        end
        m_pend = m_pend | rises;
        m_prev = irq_src;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.irq  = (m_mode == M_REQ);
        e.busy = (m_mode == M_SVC);
        e.id   = VEC_W'(m_id);
        e.pend = m_pend;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_irq", 32'(irq), 32'(e.irq));
            check("sb_busy", 32'(busy), 32'(e.busy));
            check("sb_irq_id", 32'(irq_id), 32'(e.id));
            check("sb_pending", 32'(pending), 32'(e.pend));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (rst) begin
                model_step();
                exp_q.push_back(model_out());
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    // Asynchronous reset taken away from any clock edge; outputs must clear at once.
    task automatic do_reset(input logic [N-1:0] src);
        #1;
        rst      = 1'b0;
        irq_src  = src;
        int_ack  = 1'b0;
        int_done = 1'b0;
        #1;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_irq_id", 32'(irq_id), 32'd0);
        m_mode = M_IDLE;
        m_id   = 0;
        m_pend = '0;
        m_prev = '0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        gie    = 1'b1;
        irq_en = 4'b1111;

        // Lines high across reset release each produce one edge
        do_reset(4'b1111);
        tick(2);
        check("rel_pending", 32'(pending), 32'hf);
        check("rel_irq", 32'(irq), 32'd1);
        check("rel_irq_id", 32'(irq_id), 32'd0);
        do_reset(4'b0000);
        tick(3);

        // Single source
        irq_src = 4'b0100;
        tick(2);
        check("single_irq", 32'(irq), 32'd1);
        check("single_id", 32'(irq_id), 32'd2);
        tick(2);
        pulse_ack();
        check("single_ack_pend2", 32'(pending[2]), 32'd0);
        check("single_ack_busy", 32'(busy), 32'd1);
        tick(3);
        pulse_done();
        check("single_done_busy", 32'(busy), 32'd0);
        irq_src = 4'b0000;
        tick(2);

        // Priority without preemption
        irq_src = 4'b1000;
        tick(2);
        check("prio_first_id", 32'(irq_id), 32'd3);
        irq_src = 4'b1010;
        tick(2);
        check("prio_nopreempt", 32'(irq_id), 32'd3);
        pulse_ack();
        tick();
        pulse_done();
        tick(2);
        check("prio_next_irq", 32'(irq), 32'd1);
        check("prio_next_id", 32'(irq_id), 32'd1);

        // Withdraw on mask drop, then restore
        irq_en = 4'b1101;
        tick();
        check("wd_irq", 32'(irq), 32'd0);
        check("wd_pend1", 32'(pending[1]), 32'd1);
        irq_en = 4'b1111;
        tick(2);
        check("wd_restore_irq", 32'(irq), 32'd1);
        check("wd_restore_id", 32'(irq_id), 32'd1);
        pulse_ack();
        pulse_done();
        irq_src = 4'b0000;
        tick(2);

        // Set/clear collision on source 0
        irq_src = 4'b0001;
        tick(2);
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0001;
        pulse_ack();
        check("coll_pend0", 32'(pending[0]), 32'd1);
        check("coll_busy", 32'(busy), 32'd1);
        pulse_done();
        tick();
        check("coll_again_irq", 32'(irq), 32'd1);
        check("coll_again_id", 32'(irq_id), 32'd0);
        pulse_ack();
        pulse_done();
        irq_src = 4'b0000;
        tick(2);

        // Global disable blocks requests
        gie     = 1'b0;
        irq_src = 4'b0100;
        tick(4);
        check("gie_block_irq", 32'(irq), 32'd0);
        check("gie_block_pend2", 32'(pending[2]), 32'd1);
        gie = 1'b1;
        tick(2);
        check("gie_on_irq", 32'(irq), 32'd1);
        check("gie_on_id", 32'(irq_id), 32'd2);
        pulse_ack();
        pulse_done();
        irq_src = 4'b0000;
        tick(2);

        // Stray handshakes in IDLE
        pulse_ack();
        pulse_done();
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_irq", 32'(irq), 32'd0);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            irq_src  = N'($urandom);
            irq_en   = (($urandom % 8) == 0) ? N'($urandom) : 4'b1111;
            gie      = (($urandom % 16) != 0);
            int_ack  = irq ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
            int_done = (($urandom % 4) == 0);
            tick();
        end

        // Reset in the middle of service
        gie      = 1'b1;
        irq_en   = 4'b1111;
        int_ack  = 1'b0;
        int_done = 1'b0;
        pulse_done();
        irq_src = 4'b0000;
        tick(2);
        irq_src = 4'b1000;
        tick(2);
        pulse_ack();
        check("svc_busy", 32'(busy), 32'd1);
        do_reset(4'b0000);
        tick(3);

        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
